// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM state
// encoding, the default bubble instruction and the PC increment.
package stage_if_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // issue a fetch
        S_WAIT = 2'd1,  // fetch outstanding, response wanted
        S_KILL = 2'd2,  // fetch outstanding, response will be dropped
        S_HOLD = 2'd3   // response captured while decode was stalled
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] PC_INCR           = 32'd4;

    // Redirect targets are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: the request/response FSM, the PC register and the
// one-entry hold buffer that parks a response which arrives during a stall.
// Presents a single-cycle 'load' strobe plus data to the IF/ID register.
module if_fetch_ctrl
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        load,
    output logic [31:0] load_pc4,
    output logic [31:0] load_instr
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_next4;
    logic [31:0]  target;
    logic [31:0]  hold_pc4;
    logic [31:0]  hold_instr;

    assign pc_next4  = pc + PC_INCR;  // wraps modulo 2^32 by construction
    assign target    = align_word(branch_target);
    assign imem_req  = (state == S_REQ) && !pc_src && !stall;
    assign imem_addr = pc;

    // Select what the IF/ID register takes this cycle: a fresh response or the parked one.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        load       = 1'b0;
        load_pc4   = pc_next4;
        load_instr = imem_rdata;
        if (!pc_src && !stall) begin
            case (state)
                S_WAIT: load = imem_valid;
                S_HOLD: begin
                    load       = 1'b1;
                    load_pc4   = hold_pc4;
                    load_instr = hold_instr;
                end
                default: load = 1'b0;
            endcase
        end
    end

    // Fetch FSM with PC and hold buffer; redirects always win over stalls.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            // NOTE: the hold buffer is only two words, so it is cleared on reset like any other register.
            hold_pc4   <= '0;
            hold_instr <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (pc_src)
                        pc <= target;
                    else if (!stall)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (pc_src) begin
                        pc    <= target;
                        state <= imem_valid ? S_REQ : S_KILL;
                    end else if (imem_valid) begin
                        if (stall) begin
                            hold_pc4   <= pc_next4;
                            hold_instr <= imem_rdata;
                            state      <= S_HOLD;
                        end else begin
                            pc    <= pc_next4;
                            state <= S_REQ;
                        end
                    end
                end
                S_KILL: begin
                    // A redirect here still has to be remembered even if the stale word lands now.
                    if (pc_src)
                        pc <= target;
                    if (imem_valid)
                        state <= S_REQ;
                end
                S_HOLD: begin
                    if (pc_src) begin
                        hold_pc4   <= '0;
                        hold_instr <= '0;
                        pc         <= target;
                        state      <= S_REQ;
                    end else if (!stall) begin
                        pc    <= pc_next4;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: drives a variable-latency instruction memory
// (one fetch outstanding) and owns the IF/ID pipeline register.
// Optional macro STAGE_IF_PERF_CNT_EN adds FetchCount/BubbleCount outputs.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] PCAddResult,
    output logic [31:0] Instruction,
    output logic        Valid
`ifdef STAGE_IF_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    logic        load;
    logic [31:0] load_pc4;
    logic [31:0] load_instr;

    if_fetch_ctrl #(
        .RESET_PC (RESET_PC)
    ) u_fetch_ctrl (
        .clk           (Clk),
        .reset         (Reset),
        .stall         (Stall),
        .pc_src        (PCSrc),
        .branch_target (BranchTarget),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .load          (load),
        .load_pc4      (load_pc4),
        .load_instr    (load_instr)
    );

    // IF/ID register: reset, then flush, then stall-hold, then load, else bubble.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PCAddResult <= '0;
            Instruction <= NOP_INSTR;
            Valid       <= 1'b0;
        end else if (PCSrc) begin
            Instruction <= NOP_INSTR;
            Valid       <= 1'b0;
        end else if (Stall) begin
            // Hold all three outputs for the hazard unit.
        end else if (load) begin
            PCAddResult <= load_pc4;
            Instruction <= load_instr;
            Valid       <= 1'b1;
        end else begin
            Instruction <= NOP_INSTR;
            Valid       <= 1'b0;
        end
    end

`ifdef STAGE_IF_PERF_CNT_EN
    // Performance counters: real loads, and bubbles not caused by a stall (flushes count).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FetchCount  <= '0;
            BubbleCount <= '0;
        end else begin
            if (load)
                FetchCount <= FetchCount + 32'd1;
            if (PCSrc || (!Stall && !load))
                BubbleCount <= BubbleCount + 32'd1;
        end
    end
`endif

endmodule
